bash_f_core: RTL

- Iterative bash-f sponge permutation core per STB 34.101.77: 1536-bit state, 24 x 64-bit words, ROUNDS rounds.
- Each round runs the bash-s S-box over the 8 columns, then applies word permutation P, then XORs the round constant into word S[23].
- Parametrised successor to the combinational S-box: COLS_PER_CYCLE S-box lanes, so area/throughput is selectable.
- Sits under the bash hash/AEAD controller; valid/ready on both sides.

---
 rtl/bash_f_core_pkg.sv | 42 ++++
 rtl/bash_f_core_if.sv | 27 ++
 rtl/bash_s_lane.sv | 41 ++++
 rtl/bash_f_core.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bash_f_core_pkg.sv
`default_nettype none
// ============================================================================
// bash_pkg : word/state types, column rotation and word permutation tables,
//            round-constant LFSR constants and byte-order helper for bash-f.
// Rev 1.0
// ============================================================================
package bash_pkg;

    typedef logic [63:0] word_t;
    typedef word_t [23:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [5:0] ROT_M1 [8] = '{6'd8,  6'd56, 6'd8,  6'd56, 6'd8,  6'd56, 6'd8,  6'd56};
    localparam logic [5:0] ROT_N1 [8] = '{6'd53, 6'd51, 6'd37, 6'd3,  6'd21, 6'd19, 6'd5,  6'd35};
    localparam logic [5:0] ROT_M2 [8] = '{6'd14, 6'd34, 6'd46, 6'd2,  6'd14, 6'd34, 6'd46, 6'd2};
    localparam logic [5:0] ROT_N2 [8] = '{6'd1,  6'd7,  6'd49, 6'd23, 6'd33, 6'd39, 6'd17, 6'd55};

    // New word i takes old word P_IDX[i].
    localparam logic [4:0] P_IDX [24] = '{
        5'd15, 5'd10, 5'd9,  5'd12, 5'd11, 5'd14, 5'd13, 5'd8,
        5'd17, 5'd16, 5'd19, 5'd18, 5'd21, 5'd20, 5'd23, 5'd22,
        5'd6,  5'd3,  5'd0,  5'd5,  5'd2,  5'd7,  5'd4,  5'd1
    };

    localparam word_t C1_SEED = 64'h3BF5080AC8BA94B1;
    localparam word_t C_POLY  = 64'hDC2BE1997FE0D8AE;

    function automatic word_t byte_rev64(input word_t x);
        word_t y;
        for (int b = 0; b < 8; b++) begin
            y[8*b +: 8] = x[8*(7-b) +: 8];
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bash_f_core_if.sv
`default_nettype none
// ============================================================================
// bash_f_core_if : valid/ready input and output state channels of bash_f_core.
// Rev 1.0
// ============================================================================
interface bash_f_core_if;

    logic          in_valid_i;
    logic          in_ready_o;
    logic [1535:0] state_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [1535:0] state_o;
    logic          busy_o;

    modport master (
        output in_valid_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o, busy_o
    );

    modport slave (
        input  in_valid_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/bash_s_lane.sv
`default_nettype none
// ============================================================================
// bash_s_lane : combinational bash-s S-box on numeric 64-bit words with
//               run-time rotation amounts (barrel rotators).
// Rev 1.0
// ============================================================================
module bash_s_lane
    import bash_pkg::*;
(
    input  word_t      w0,
    input  word_t      w1,
    input  word_t      w2,
    input  logic [5:0] m1,
    input  logic [5:0] n1,
    input  logic [5:0] m2,
    input  logic [5:0] n2,
    output word_t      y0,
    output word_t      y1,
    output word_t      y2
);

    function automatic word_t rot_hi(input word_t x, input logic [5:0] s);
        logic [127:0] d;
        d = {x, x} << s;
        return d[127:64];
    endfunction

    word_t a0, a1, a2, t1;

    always_comb begin
        a0 = w0 ^ w1 ^ w2;
        t1 = w1 ^ rot_hi(a0, n1);
        a1 = rot_hi(w0, m1) ^ t1;
        a2 = w2 ^ rot_hi(w2, m2) ^ rot_hi(t1, n2);
        y0 = a0 ^ (~a2 | a1);
        y1 = a1 ^ (a0 | a2);
        y2 = a2 ^ (a0 & a1);
    end

endmodule
`default_nettype wire

// File: rtl/bash_f_core.sv
`default_nettype none
// ============================================================================
// bash_f_core : iterative bash-f permutation, COLS_PER_CYCLE S-box lanes.
//               BASH_F_ZEROIZE_EN clears the state register on output hand-off.
// Rev 1.0
// ============================================================================
module bash_f_core
    import bash_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8,
    parameter int ROUNDS         = 24
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    bash_f_core_if.slave  bus
);

    localparam int GROUPS = 8 / COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4 && COLS_PER_CYCLE != 8) begin : g_bad_cols
        $error("bash_f_core: COLS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (ROUNDS < 1 || ROUNDS > 24) begin : g_bad_rounds
        $error("bash_f_core: ROUNDS must be in 1..24");
    end

    fsm_t       fsm, fsm_next;
    state_t     state_reg, sbox_state, round_state;
    word_t      rc, lfsr_next;
    logic [2:0] grp;
    logic [4:0] round_cnt;
    logic       last_grp, last_round;

    word_t      lane_y0  [COLS_PER_CYCLE];
    word_t      lane_y1  [COLS_PER_CYCLE];
    word_t      lane_y2  [COLS_PER_CYCLE];
    logic [2:0] lane_col [COLS_PER_CYCLE];

    assign last_grp   = (grp == 3'(GROUPS - 1));
    assign last_round = (round_cnt == 5'(ROUNDS - 1));
    assign lfsr_next  = (rc >> 1) ^ (rc[0] ? C_POLY : 64'h0);
    assign bus.state_o = state_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fsm <= ST_IDLE;
        else       fsm <= fsm_next;
    end

    always_comb begin
        fsm_next        = fsm;
        bus.in_ready_o  = 1'b0;
        bus.busy_o      = 1'b0;
        bus.out_valid_o = 1'b0;
        case (fsm)
            ST_IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) fsm_next = ST_RUN;
            end
            ST_RUN: begin
                bus.busy_o = 1'b1;
                if (last_grp && last_round) fsm_next = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) fsm_next = ST_IDLE;
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    // Stored words are in byte-stream order; the S-box works on numeric values.
    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        logic [4:0] i0;
        word_t      y0, y1, y2;

        assign lane_col[l] = 3'(int'(grp) * COLS_PER_CYCLE + l);
        assign i0          = {2'b00, lane_col[l]};

        bash_s_lane u_lane (
            .w0 (byte_rev64(state_reg[i0])),
            .w1 (byte_rev64(state_reg[i0 + 5'd8])),
            .w2 (byte_rev64(state_reg[i0 + 5'd16])),
            .m1 (ROT_M1[lane_col[l]]),
            .n1 (ROT_N1[lane_col[l]]),
            .m2 (ROT_M2[lane_col[l]]),
            .n2 (ROT_N2[lane_col[l]]),
            .y0 (y0),
            .y1 (y1),
            .y2 (y2)
        );

        assign lane_y0[l] = byte_rev64(y0);
        assign lane_y1[l] = byte_rev64(y1);
        assign lane_y2[l] = byte_rev64(y2);
    end

    always_comb begin
        sbox_state = state_reg;
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
            sbox_state[{2'b00, lane_col[l]}]         = lane_y0[l];
            sbox_state[{2'b00, lane_col[l]} + 5'd8]  = lane_y1[l];
            sbox_state[{2'b00, lane_col[l]} + 5'd16] = lane_y2[l];
        end
        for (int i = 0; i < 24; i++) begin
            round_state[i] = sbox_state[P_IDX[i]];
        end
        round_state[23] = round_state[23] ^ byte_rev64(rc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= '0;
            rc        <= '0;
            grp       <= '0;
            round_cnt <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (bus.in_valid_i) begin
                        state_reg <= bus.state_i;
                        rc        <= C1_SEED;
                        grp       <= '0;
                        round_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (last_grp) begin
                        state_reg <= round_state;
                        rc        <= lfsr_next;
                        grp       <= '0;
                        round_cnt <= round_cnt + 5'd1;
                    end else begin
                        state_reg <= sbox_state;
                        grp       <= grp + 3'd1;
                    end
                end
                ST_DONE: begin
`ifdef BASH_F_ZEROIZE_EN
                    if (bus.out_ready_i) state_reg <= '0;
`else
                    state_reg <= state_reg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
